// File: rtl/wb_trace_pkg.sv
// Shared types and helpers for the writeback commit-trace FIFO.
// WB_TRACE_TS_EN adds a 32-bit timestamp field to each entry.
package wb_trace_pkg;

    localparam int unsigned TRACE_DEPTH_DEFAULT = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic        ena;
        logic [4:0]  wb_reg;
        logic [31:0] value;
`ifdef WB_TRACE_TS_EN
        logic [31:0] ts;
`endif
    } trace_entry_t;

    // Writes to x0 are not real writes, so they carry no register or value.
    function automatic trace_entry_t normalize_entry(input logic [31:0] pc,
                                                     input logic        ena,
                                                     input logic [4:0]  wb_reg,
                                                     input logic [31:0] value);
        trace_entry_t e;
        e.pc     = pc;
        e.ena    = ena & (wb_reg != 5'd0);
        e.wb_reg = e.ena ? wb_reg : 5'd0;
        e.value  = e.ena ? value : 32'd0;
`ifdef WB_TRACE_TS_EN
        e.ts     = 32'd0;
`endif
        return e;
    endfunction

endpackage

// File: rtl/wb_trace_fifo_if.sv
// Writeback debug capture port plus the valid/ready trace drain stream.
interface wb_trace_if;
    logic        debug_wb_have_inst;
    logic [31:0] debug_wb_pc;
    logic        debug_wb_ena;
    logic [4:0]  debug_wb_reg;
    logic [31:0] debug_wb_value;

    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic        trace_ena;
    logic [4:0]  trace_reg;
    logic [31:0] trace_value;
    logic [31:0] trace_ts;

    modport master (
        output debug_wb_have_inst, debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value,
        output trace_ready,
        input  trace_valid, trace_pc, trace_ena, trace_reg, trace_value, trace_ts
    );

    modport slave (
        input  debug_wb_have_inst, debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value,
        input  trace_ready,
        output trace_valid, trace_pc, trace_ena, trace_reg, trace_value, trace_ts
    );
endinterface

// File: rtl/wb_trace_mem.sv
// Trace entry storage: synchronous write, asynchronous read for FWFT head access.
module wb_trace_mem
    import wb_trace_pkg::*;
#(
    parameter int unsigned DEPTH = TRACE_DEPTH_DEFAULT,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  trace_entry_t  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output trace_entry_t  rdata_o
);

    trace_entry_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wb_trace_fifo.sv
// Commit-trace FIFO behind the core writeback port; never stalls, drops and counts on full.
// Define WB_TRACE_TS_EN to stamp each entry with a free-running cycle count.
module wb_trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int unsigned DEPTH  = TRACE_DEPTH_DEFAULT,
    parameter int unsigned DROP_W = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              clear,
    wb_trace_if.slave         tr,
    output logic [CW-1:0]     fifo_count,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);

    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              full, pop, push_acc, drop;
    trace_entry_t      wr_entry, rd_entry;
`ifdef WB_TRACE_TS_EN
    logic [31:0]       ts_q, ts_d;
`endif

    assign full     = (count_q == CW'(DEPTH));
    assign pop      = tr.trace_valid & tr.trace_ready;
    // A pop at full frees the slot the incoming push lands in.
    assign push_acc = tr.debug_wb_have_inst & (~full | pop);
    assign drop     = tr.debug_wb_have_inst & full & ~pop;

    always_comb begin
        wr_entry   = normalize_entry(tr.debug_wb_pc, tr.debug_wb_ena, tr.debug_wb_reg,
                                     tr.debug_wb_value);
        wptr_d     = wptr_q + AW'(push_acc);
        rptr_d     = rptr_q + AW'(pop);
        count_d    = count_q + CW'(push_acc) - CW'(pop);
        overflow_d = overflow_q | drop;
        drop_d     = (drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
`ifdef WB_TRACE_TS_EN
        wr_entry.ts = ts_q;
        ts_d        = ts_q + 32'd1;
`endif
        if (clear) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
`ifdef WB_TRACE_TS_EN
            ts_d       = '0;
`endif
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
`ifdef WB_TRACE_TS_EN
            ts_q       <= '0;
`endif
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
`ifdef WB_TRACE_TS_EN
            ts_q       <= ts_d;
`endif
        end
    end

    wb_trace_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (cpu_clk),
        .we_i    (push_acc & ~clear),
        .waddr_i (wptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rptr_q),
        .rdata_o (rd_entry)
    );

    assign tr.trace_valid = (count_q != '0);
    assign tr.trace_pc    = rd_entry.pc;
    assign tr.trace_ena   = rd_entry.ena;
    assign tr.trace_reg   = rd_entry.wb_reg;
    assign tr.trace_value = rd_entry.value;
`ifdef WB_TRACE_TS_EN
    assign tr.trace_ts    = rd_entry.ts;
`else
    assign tr.trace_ts    = 32'd0;
`endif

    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed self-checking bench for wb_trace_fifo (DEPTH=16, DROP_W=16).
module tb_wb_trace_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic [15:0] drop_count;
    int          n_checks = 0;
    int          n_fails  = 0;

    always #5 clk = ~clk;

    wb_trace_if tr ();

    wb_trace_fifo #(
        .DEPTH  (16),
        .DROP_W (16)
    ) dut (
        .cpu_clk    (clk),
        .cpu_rst    (rst_n),
        .clear      (clear),
        .tr         (tr),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic have, input logic [31:0] pc, input logic ena,
                         input logic [4:0] rd, input logic [31:0] val);
        tr.debug_wb_have_inst = have;
        tr.debug_wb_pc        = pc;
        tr.debug_wb_ena       = ena;
        tr.debug_wb_reg       = rd;
        tr.debug_wb_value     = val;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        tr.trace_ready = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (3) step();
        check("rst_valid", {31'd0, tr.trace_valid}, 32'd0);
        check("rst_count", {27'd0, fifo_count}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_drop", {16'd0, drop_count}, 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_valid", {31'd0, tr.trace_valid}, 32'd0);
        check("idle_count", {27'd0, fifo_count}, 32'd0);

        // Single push, then pop.
        drive(1'b1, 32'h8000_0000, 1'b1, 5'd5, 32'h1234);
        step();
        drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("one_valid", {31'd0, tr.trace_valid}, 32'd1);
        check("one_pc", tr.trace_pc, 32'h8000_0000);
        check("one_ena", {31'd0, tr.trace_ena}, 32'd1);
        check("one_reg", {27'd0, tr.trace_reg}, 32'd5);
        check("one_value", tr.trace_value, 32'h1234);
        check("one_count", {27'd0, fifo_count}, 32'd1);
`ifndef WB_TRACE_TS_EN
        check("ts_tied", tr.trace_ts, 32'd0);
`endif
        tr.trace_ready = 1'b1;
        step();
        tr.trace_ready = 1'b0;
        check("one_pop_valid", {31'd0, tr.trace_valid}, 32'd0);
        check("one_pop_count", {27'd0, fifo_count}, 32'd0);

        // Normalization, pushed at empty with ready high: no bypass.
        drive(1'b1, 32'h40, 1'b1, 5'd0, 32'hDEAD);
        tr.trace_ready = 1'b1;
        step();
        drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("nb_valid", {31'd0, tr.trace_valid}, 32'd1);
        check("nb_count", {27'd0, fifo_count}, 32'd1);
        check("norm0_pc", tr.trace_pc, 32'h40);
        check("norm0_ena", {31'd0, tr.trace_ena}, 32'd0);
        check("norm0_reg", {27'd0, tr.trace_reg}, 32'd0);
        check("norm0_value", tr.trace_value, 32'd0);
        step();
        tr.trace_ready = 1'b0;
        check("norm0_drain", {27'd0, fifo_count}, 32'd0);
        drive(1'b1, 32'h44, 1'b0, 5'd3, 32'h77);
        step();
        drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("normena_ena", {31'd0, tr.trace_ena}, 32'd0);
        check("normena_reg", {27'd0, tr.trace_reg}, 32'd0);
        check("normena_value", tr.trace_value, 32'd0);
        tr.trace_ready = 1'b1;
        step();
        tr.trace_ready = 1'b0;

        // Fill to 16, then three dropped pushes.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i, 1'b1, 5'(i + 1), i * 3);
            step();
        end
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 100 + j, 1'b1, 5'd9, 32'hBAD);
            step();
        end
        drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("fill_count", {27'd0, fifo_count}, 32'd16);
        check("fill_ovf", {31'd0, overflow}, 32'd1);
        check("fill_drop", {16'd0, drop_count}, 32'd3);
        tr.trace_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_pc%0d", i), tr.trace_pc, i);
            check($sformatf("drain_val%0d", i), tr.trace_value, i * 3);
            check($sformatf("drain_cnt%0d", i), {27'd0, fifo_count}, 16 - i);
            step();
        end
        tr.trace_ready = 1'b0;
        check("drain_empty", {31'd0, tr.trace_valid}, 32'd0);
        check("drain_ovf_sticky", {31'd0, overflow}, 32'd1);

        // Full with simultaneous push and pop; pointers wrap.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h200 + i, 1'b1, 5'd1, i);
            step();
        end
        tr.trace_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 32'h300 + k, 1'b1, 5'd2, k);
            check($sformatf("pp_cnt%0d", k), {27'd0, fifo_count}, 32'd16);
            check($sformatf("pp_pc%0d", k), tr.trace_pc,
                  (k < 16) ? 32'h200 + k : 32'h300 + k - 16);
            step();
        end
        drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("pp_drop", {16'd0, drop_count}, 32'd3);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("pp_tail%0d", k), tr.trace_pc, 32'h304 + k);
            step();
        end
        tr.trace_ready = 1'b0;
        check("pp_empty", {31'd0, tr.trace_valid}, 32'd0);

        // Clear beats a same-cycle push and pop.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h500 + i, 1'b1, 5'd4, i);
            step();
        end
        check("clr_pre", {27'd0, fifo_count}, 32'd5);
        drive(1'b1, 32'h999, 1'b1, 5'd4, 32'h1);
        tr.trace_ready = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        tr.trace_ready = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("clr_count", {27'd0, fifo_count}, 32'd0);
        check("clr_ovf", {31'd0, overflow}, 32'd0);
        check("clr_drop", {16'd0, drop_count}, 32'd0);
        check("clr_valid", {31'd0, tr.trace_valid}, 32'd0);
        step();
        check("clr_valid2", {31'd0, tr.trace_valid}, 32'd0);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h600 + i, 1'b1, 5'd6, i);
            step();
        end
        drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("mid_pre", {27'd0, fifo_count}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_count", {27'd0, fifo_count}, 32'd0);
        check("mid_valid", {31'd0, tr.trace_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        drive(1'b1, 32'hABC, 1'b1, 5'd7, 32'h55);
        step();
        drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("post_rst_pc", tr.trace_pc, 32'hABC);
        check("post_rst_count", {27'd0, fifo_count}, 32'd1);
        tr.trace_ready = 1'b1;
        step();
        tr.trace_ready = 1'b0;

`ifdef WB_TRACE_TS_EN
        // Counter restarts at 0 after clear; pushes land at stamps 10 and 13.
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (10) step();
        drive(1'b1, 32'h700, 1'b1, 5'd8, 32'd1);
        step();
        drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        step();
        drive(1'b1, 32'h704, 1'b1, 5'd8, 32'd2);
        step();
        drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("ts_first", tr.trace_ts, 32'd10);
        tr.trace_ready = 1'b1;
        step();
        tr.trace_ready = 1'b0;
        check("ts_second", tr.trace_ts, 32'd13);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
